// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the PWM output block.
package pwm_pkg;

    localparam int unsigned PWM_W           = 8;
    localparam int unsigned NUM_OUT         = 16;
    localparam int unsigned CLK_DIV_DEFAULT = 13;

    localparam logic [PWM_W-1:0] PWM_MAX = 8'hFF;

    // Duty compare; full-scale duty is a solid high with no one-step low gap.
    function automatic logic pwm_compare(input logic [PWM_W-1:0] cnt,
                                         input logic [PWM_W-1:0] duty);
        return (duty == PWM_MAX) ? 1'b1 : (cnt < duty);
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler plus free-running 8-bit PWM counter shared by all pins.
module pwm_timebase #(
    parameter int unsigned CLK_DIV = pwm_pkg::CLK_DIV_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    output logic [pwm_pkg::PWM_W-1:0] pwm_cnt,
    output logic                      tick_c,
    output logic                      wrap_c
);
    import pwm_pkg::*;

    localparam int unsigned PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [PRE_W-1:0] pre_cnt;

    // Tick on the last prescaler count; with CLK_DIV==1 pre_cnt stays 0 and ticks every cycle.
    assign tick_c = (pre_cnt == PRE_W'(CLK_DIV - 1));
    assign wrap_c = tick_c & (pwm_cnt == PWM_MAX);

    // Prescaler and PWM counter; the counter wraps 255->0 on its own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
        end else begin
            if (tick_c) begin
                pre_cnt <= '0;
                pwm_cnt <= pwm_cnt + PWM_W'(1);
            end else begin
                pre_cnt <= pre_cnt + PRE_W'(1);
            end
        end
    end

endmodule

// File: rtl/pwm_peripheral.sv
// Drives 16 pins as off, static on, or PWM with a shared, period-buffered duty.
module pwm_peripheral #(
    parameter int unsigned CLK_DIV = pwm_pkg::CLK_DIV_DEFAULT,
    parameter int unsigned NUM_OUT = pwm_pkg::NUM_OUT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [pwm_pkg::PWM_W-1:0] en_reg_out_7_0,
    input  logic [pwm_pkg::PWM_W-1:0] en_reg_out_15_8,
    input  logic [pwm_pkg::PWM_W-1:0] en_reg_pwm_7_0,
    input  logic [pwm_pkg::PWM_W-1:0] en_reg_pwm_15_8,
    input  logic [pwm_pkg::PWM_W-1:0] pwm_duty_cycle,
    output logic [NUM_OUT-1:0]        out,
    output logic                      period_start
);
    import pwm_pkg::*;

    logic [PWM_W-1:0]   pwm_cnt;
    logic [PWM_W-1:0]   duty_active;
    logic               tick_c;
    logic               wrap_c;
    logic               pwm_high_c;
    logic [NUM_OUT-1:0] en_out_c;
    logic [NUM_OUT-1:0] en_pwm_c;
    logic               unused_tick;

    pwm_timebase #(
        .CLK_DIV (CLK_DIV)
    ) u_timebase (
        .clk     (clk),
        .rst_n   (rst),
        .pwm_cnt (pwm_cnt),
        .tick_c  (tick_c),
        .wrap_c  (wrap_c)
    );

    // Tick is only consumed through wrap in this block.
    assign unused_tick = tick_c;

    assign en_out_c   = NUM_OUT'({en_reg_out_15_8, en_reg_out_7_0});
    assign en_pwm_c   = NUM_OUT'({en_reg_pwm_15_8, en_reg_pwm_7_0});
    assign pwm_high_c = pwm_compare(pwm_cnt, duty_active);

    // Duty shadow load at wrap, period marker, and registered pin mux.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            duty_active  <= '0;
            period_start <= 1'b0;
            out          <= '0;
        end else begin
            period_start <= wrap_c;
            if (wrap_c) begin
                duty_active <= pwm_duty_cycle;
            end
            out <= en_out_c & (~en_pwm_c | {NUM_OUT{pwm_high_c}});
        end
    end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed bench for pwm_peripheral with the default divider (period 3328 clks).
module tb_pwm_peripheral;

    localparam int PERIOD = 13 * 256;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  en_reg_out_7_0;
    logic [7:0]  en_reg_out_15_8;
    logic [7:0]  en_reg_pwm_7_0;
    logic [7:0]  en_reg_pwm_15_8;
    logic [7:0]  pwm_duty_cycle;
    logic [15:0] out;
    logic        period_start;

    int tests = 0;
    int fails = 0;

    pwm_peripheral dut (
        .clk             (clk),
        .rst             (rst),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .out             (out),
        .period_start    (period_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Sample at negedges until period_start is seen (bounded); accumulate out[0] highs and OR of out.
    task automatic run_until_ps(output int n, output int hi0, output logic [15:0] hi_or);
        n = 0;
        hi0 = 0;
        hi_or = '0;
        do begin
            @(negedge clk);
            n++;
            if (out[0] === 1'b1) hi0++;
            hi_or |= out;
        end while (period_start !== 1'b1 && n < 5000);
    endtask

    task automatic count_cycles(input int k, inout int hi0, inout logic [15:0] hi_or);
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            if (out[0] === 1'b1) hi0++;
            hi_or |= out;
        end
    endtask

    initial begin
        int          n;
        int          n2;
        int          hi;
        int          hi2;
        int          bad;
        logic [15:0] o;
        logic [15:0] o2;

        rst             = 1'b0;
        en_reg_out_7_0  = 8'h00;
        en_reg_out_15_8 = 8'h00;
        en_reg_pwm_7_0  = 8'h00;
        en_reg_pwm_15_8 = 8'h00;
        pwm_duty_cycle  = 8'h80;

        #12;
        chk("reset_out", 32'(out), 32'h0);
        chk("reset_ps", 32'(period_start), 32'h0);

        // Disabled pins, two periods
        @(negedge clk);
        rst = 1'b1;
        run_until_ps(n, hi, o);
        chk("first_ps_gap", n, PERIOD);
        chk("idle_out_p1", 32'(o), 32'h0);
        run_until_ps(n, hi, o);
        chk("second_ps_gap", n, PERIOD);
        chk("idle_out_p2", 32'(o), 32'h0);

        // Static on, then partial disable
        en_reg_out_7_0  = 8'hFF;
        en_reg_out_15_8 = 8'hFF;
        @(negedge clk);
        chk("static_on_first", 32'(out), 32'hFFFF);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out !== 16'hFFFF) bad++;
        end
        chk("static_on_hold", bad, 0);
        en_reg_out_15_8 = 8'h00;
        @(negedge clk);
        chk("en_out_00ff", 32'(out), 32'h00FF);

        // PWM on pin 0 at 50%
        en_reg_out_7_0 = 8'h01;
        en_reg_pwm_7_0 = 8'h01;
        pwm_duty_cycle = 8'h80;
        run_until_ps(n, hi, o);
        chk("pwm_sync_bound", 32'(n <= PERIOD), 32'h1);
        run_until_ps(n, hi, o);
        chk("pwm80_gap", n, PERIOD);
        chk("pwm80_high", hi, 1664);
        chk("pwm80_other_pins", 32'(o & 16'hFFFE), 32'h0);

        // Duty 0x00: next period is all low
        pwm_duty_cycle = 8'h00;
        run_until_ps(n, hi, o);
        chk("pwm80_still_high", hi, 1664);
        run_until_ps(n, hi, o);
        chk("pwm00_high", hi, 0);

        // Duty 0xFF: two consecutive periods all high
        pwm_duty_cycle = 8'hFF;
        run_until_ps(n, hi, o);
        chk("pwm00_still_low", hi, 0);
        run_until_ps(n, hi, o);
        run_until_ps(n2, hi2, o2);
        chk("pwmff_two_periods", hi + hi2, 2 * PERIOD);

        // Mid-period duty change 0x40 -> 0xC0 at pwm_cnt==100
        pwm_duty_cycle = 8'h40;
        run_until_ps(n, hi, o);
        hi = 0;
        o  = '0;
        count_cycles(100 * 13, hi, o);
        pwm_duty_cycle = 8'hC0;
        run_until_ps(n, hi2, o2);
        chk("change_gap", n + 100 * 13, PERIOD);
        chk("change_keep_40", hi + hi2, 832);
        run_until_ps(n, hi, o);
        chk("change_new_c0", hi, 2496);

        // Async reset at pwm_cnt==150
        hi = 0;
        o  = '0;
        count_cycles(150 * 13, hi, o);
        chk("pre_reset_high", 32'(out[0]), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_reset_out", 32'(out), 32'h0);
        chk("async_reset_ps", 32'(period_start), 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        run_until_ps(n, hi, o);
        chk("post_reset_gap", n, PERIOD);
        chk("post_reset_low", hi, 0);
        run_until_ps(n, hi, o);
        chk("post_reset_c0", hi, 2496);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pwm_peripheral.md
Name: pwm_peripheral

Overview:
Consumes the five configuration registers written by spi_peripheral and drives 16 output pins. Each pin is independently off, statically on, or PWM-modulated with a shared 8-bit duty cycle. A prescaler divides the system clock down to the PWM counter rate: about 3 kHz PWM at 10 MHz with defaults. Duty changes are double-buffered and take effect only at a period boundary, so no glitched periods are produced.

Parameters:
CLK_DIV, 13, system clocks per PWM counter step (>=1); PWM period = CLK_DIV*256 clk cycles
NUM_OUT, 16, number of output pins (fixed at 16 for this design; the parameter documents the width)

Ports:
clk  input  1  system clock; the same domain as the spi_peripheral register outputs
rst  input  1  asynchronous, active-low reset
en_reg_out_7_0  input  8  output enable, pins 7:0
en_reg_out_15_8  input  8  output enable, pins 15:8
en_reg_pwm_7_0  input  8  PWM mode select, pins 7:0
en_reg_pwm_15_8  input  8  PWM mode select, pins 15:8
pwm_duty_cycle  input  8  requested duty; 0x00 = 0%, 0xFF = 100%
out  output  16  pin drive; out[7:0] to uo_out, out[15:8] to uio_out
period_start  output  1  one-clk pulse marking PWM counter wrap to 0 (debug/verification)

Behaviour:
- Reset (rst=0, async): pre_cnt=0, pwm_cnt=0, duty_active=0x00, out=16'h0000, period_start=0.
- Prescaler: pre_cnt counts 0..CLK_DIV-1, wraps to 0. tick=1 when pre_cnt==CLK_DIV-1. If CLK_DIV==1, tick is asserted every cycle.
- PWM counter: 8-bit pwm_cnt increments on tick and wraps 255->0 naturally. There is no hold state.
- Period boundary: wrap = tick & (pwm_cnt==255).
  - On wrap: duty_active <= pwm_duty_cycle, and period_start <= 1 for exactly one clk.
  - Otherwise period_start <= 0.
- Duty buffering:
  - A pwm_duty_cycle change mid-period has no effect until the next wrap.
  - Multiple changes within one period: only the value present on the wrap cycle is used.
- Compare: pwm_high = (duty_active==8'hFF) ? 1 : (pwm_cnt < duty_active).
  - 0x00 gives a constant 0.
  - 0xFF gives a constant 1 (no single-step low gap).
  - Duty d in 1..254 gives high for d*CLK_DIV clk cycles per period.
- Pin mux, per bit i, with en_out = {en_reg_out_15_8, en_reg_out_7_0} and en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0}:
  - en_out[i]=0: out[i]=0, regardless of en_pwm[i].
  - en_out[i]=1, en_pwm[i]=0: out[i]=1.
  - en_out[i]=1, en_pwm[i]=1: out[i]=pwm_high.
- Latency:
  - out is registered and reflects the enable inputs and the pwm_cnt/duty_active of the previous clk (1-cycle latency).
  - Enable changes are not buffered; they apply on the next clk edge.
- All PWM-mode pins share one pwm_cnt and are phase-aligned (same rising edge).
- Reset mid-period: everything returns to reset values immediately. After release the first period starts at pwm_cnt=0 with duty_active=0, so PWM pins stay low until the first wrap (256*CLK_DIV clks) loads the real duty.
- Input values are quasi-static in the clk domain. No resynchronisation is done in this block.

Decomposition:
- Shared package pwm_pkg holds:
  - PWM_W=8
  - PWM_MAX=8'hFF
  - CLK_DIV_DEFAULT=13
  - NUM_OUT=16
- One sub-module, pwm_timebase. It contains the prescaler plus pwm_cnt, and outputs pwm_cnt[7:0], tick and wrap.
- The duty shadow register, compare and 16-bit output mux stay in pwm_peripheral.

Test Plan:
- Reset, then enables=0, duty=0x80, run 2 periods -> out==0x0000 throughout, and period_start pulses every 3328 clks.
- en_out=0xFFFF, en_pwm=0x0000 -> out==0xFFFF from the second clk after the write and static thereafter. Then en_out=0x00FF -> out==0x00FF one clk later.
- en_out=en_pwm=0x0001, duty=0x80, after the first wrap -> out[0] high 1664 clks, low 1664 clks per 3328-clk period, and out[15:1]==0.
- Duty 0x00 -> out[0] constant 0 for a full period. Duty 0xFF -> out[0] constant 1 across two consecutive periods with no low cycle.
- Duty changed 0x40->0xC0 at pwm_cnt==100 -> current period keeps 0x40 (832 clks high), and the next period, starting at period_start, shows 0xC0 (2496 clks high).
- Assert rst at pwm_cnt==150 with out[0] in PWM mode -> out==0 immediately (async). After release, pwm_cnt restarts at 0 and out[0] stays low until the first period_start.
